gem_fiber_frame_rx: RTL and testbench

// Receive-side deframer for the 3.2 Gb/s GEM trigger link. Takes 32-bit/4-bit-K words from the GTX RX
// (8b10b-decoded, comma-aligned) at 80 MHz and rebuilds each 40 MHz frame into 56-bit S-bit cluster data.

---
 rtl/gem_fiber_frame_rx.sv | 187 ++++++++++++++++++
 tb/tb_gem_fiber_frame_rx.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gem_fiber_frame_rx.sv
// rtl/gem_fiber_frame_rx.sv - GEM trigger link RX deframer: separator lock, 56-bit frame rebuild, error counting
module gem_fiber_frame_rx #(
    parameter int LOCK_FRAMES = 8,
    parameter int UNLOCK_ERRS = 4,
    parameter int CNT_W       = 16
) (
    input  logic             TRG_CLK80,
    input  logic             TRG_TXRESETDONE,
    input  logic [31:0]      RX_DATA,
    input  logic [3:0]       RX_ISK,
    input  logic [3:0]       RX_CODE_ERR,
    input  logic             ERR_CNT_RST,
    output logic [55:0]      GEM_DATA,
    output logic             GEM_OVERFLOW,
    output logic             FRAME_VALID,
    output logic [7:0]       FRAME_SEP,
    output logic             LOCKED,
    output logic             LINK_IDLE,
    output logic             FRAME_ERR,
    output logic             SEQ_ERR,
    output logic [CNT_W-1:0] FRAME_ERR_CNT,
    output logic [CNT_W-1:0] SEQ_ERR_CNT
);
    localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
    localparam int BAD_W  = $clog2(UNLOCK_ERRS + 1);

    localparam logic [7:0] SEP_BC = 8'hBC;
    localparam logic [7:0] SEP_F7 = 8'hF7;
    localparam logic [7:0] SEP_FB = 8'hFB;
    localparam logic [7:0] SEP_FD = 8'hFD;
    localparam logic [7:0] SEP_FC = 8'hFC;

    localparam logic SLOT_DATA = 1'b0;
    localparam logic SLOT_SEP  = 1'b1;

    typedef enum logic [1:0] {ST_SEARCH, ST_CONFIRM, ST_LOCKED} state_t;
    typedef enum logic [1:0] {CL_BAD, CL_IDLE, CL_SEP, CL_DATA} word_class_t;

    function automatic logic [7:0] sep_succ(input logic [7:0] s);
        case (s)
            SEP_BC:  sep_succ = SEP_F7;
            SEP_F7:  sep_succ = SEP_FB;
            SEP_FB:  sep_succ = SEP_FD;
            default: sep_succ = SEP_BC;
        endcase
    endfunction

    state_t            r_state;
    logic              r_slot;
    logic [7:0]        r_exp_sep;
    logic [31:0]       r_hold;
    logic              r_prev_data;
    logic              r_err_seen;
    logic [GOOD_W-1:0] r_good;
    logic [BAD_W-1:0]  r_bad;

    word_class_t w_class;
    logic [7:0]  w_sep;
    logic        w_sep_code;
    logic        w_is_sep;
    logic        w_active;
    logic        w_slot_err;
    logic        w_frame_err;
    logic        w_seq_err;
    logic        w_good_frame;
    logic        w_next_slot;
    logic [7:0]  w_exp_next;

    assign w_sep      = RX_DATA[7:0];
    assign w_sep_code = (w_sep == SEP_BC) || (w_sep == SEP_F7) || (w_sep == SEP_FB) ||
                        (w_sep == SEP_FD) || (w_sep == SEP_FC);

    always_comb begin
        w_class = CL_BAD;
        if (|RX_CODE_ERR)
            w_class = CL_BAD;
        else if (RX_ISK == 4'b0101 && RX_DATA == 32'h50BC50BC)
            w_class = CL_IDLE;
        else if (RX_ISK == 4'b0001 && w_sep_code)
            w_class = CL_SEP;
        else if (RX_ISK == 4'b0000)
            w_class = CL_DATA;
    end

    assign w_is_sep     = (w_class == CL_SEP);
    assign w_active     = (r_state != ST_SEARCH);
    // Idle words never count against the frame: the partner is simply in reset.
    assign w_slot_err   = (w_class != CL_IDLE) &&
                          ((r_slot == SLOT_DATA) ? (w_class != CL_DATA) : (w_class != CL_SEP));
    assign w_frame_err  = w_active && w_slot_err && !r_err_seen;
    assign w_seq_err    = w_active && w_is_sep && (w_sep != SEP_FC) && (w_sep != r_exp_sep);
    assign w_good_frame = w_is_sep && (r_slot == SLOT_SEP) && r_prev_data;
    assign w_next_slot  = w_is_sep ? SLOT_DATA : ~r_slot;
    assign w_exp_next   = (w_sep == SEP_FC) ? sep_succ(r_exp_sep) : sep_succ(w_sep);

    always_ff @(posedge TRG_CLK80 or negedge TRG_TXRESETDONE) begin
        if (!TRG_TXRESETDONE) begin
            r_state       <= ST_SEARCH;
            r_slot        <= SLOT_DATA;
            r_exp_sep     <= SEP_BC;
            r_hold        <= '0;
            r_prev_data   <= 1'b0;
            r_err_seen    <= 1'b0;
            r_good        <= '0;
            r_bad         <= '0;
            GEM_DATA      <= '0;
            GEM_OVERFLOW  <= 1'b0;
            FRAME_VALID   <= 1'b0;
            FRAME_SEP     <= '0;
            LOCKED        <= 1'b0;
            LINK_IDLE     <= 1'b0;
            FRAME_ERR     <= 1'b0;
            SEQ_ERR       <= 1'b0;
            FRAME_ERR_CNT <= '0;
            SEQ_ERR_CNT   <= '0;
        end else begin
            FRAME_VALID <= 1'b0;
            FRAME_ERR   <= w_frame_err;
            SEQ_ERR     <= w_seq_err;
            LINK_IDLE   <= (w_class == CL_IDLE);

            r_slot      <= w_next_slot;
            r_prev_data <= (w_class == CL_DATA) && (r_slot == SLOT_DATA);
            if (w_class == CL_DATA && r_slot == SLOT_DATA)
                r_hold <= RX_DATA;
            // Error latch spans one DATA+SEP pair so a frame is never charged twice.
            r_err_seen  <= (w_next_slot == SLOT_SEP) && (r_err_seen || w_slot_err);
            if (w_is_sep)
                r_exp_sep <= w_exp_next;

            if (ERR_CNT_RST)
                FRAME_ERR_CNT <= '0;
            else if (w_frame_err && !(&FRAME_ERR_CNT))
                FRAME_ERR_CNT <= FRAME_ERR_CNT + CNT_W'(1);

            if (ERR_CNT_RST)
                SEQ_ERR_CNT <= '0;
            else if (w_seq_err && !(&SEQ_ERR_CNT))
                SEQ_ERR_CNT <= SEQ_ERR_CNT + CNT_W'(1);

            if (w_class == CL_IDLE) begin
                r_state <= ST_SEARCH;
                LOCKED  <= 1'b0;
            end else begin
                case (r_state)
                    ST_SEARCH: begin
                        if (w_is_sep) begin
                            r_state <= ST_CONFIRM;
                            r_good  <= '0;
                        end
                    end
                    ST_CONFIRM: begin
                        if (w_frame_err || w_seq_err) begin
                            r_state <= ST_SEARCH;
                        end else if (w_good_frame) begin
                            if (r_good == GOOD_W'(LOCK_FRAMES - 1)) begin
                                r_state <= ST_LOCKED;
                                LOCKED  <= 1'b1;
                                r_bad   <= '0;
                            end
                            r_good <= r_good + GOOD_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        if (w_good_frame) begin
                            FRAME_VALID  <= 1'b1;
                            GEM_DATA     <= {r_hold, RX_DATA[31:8]};
                            GEM_OVERFLOW <= (w_sep == SEP_FC);
                            FRAME_SEP    <= w_sep;
                            r_bad        <= '0;
                        end else if (w_frame_err) begin
                            if (r_bad == BAD_W'(UNLOCK_ERRS - 1)) begin
                                r_state <= ST_SEARCH;
                                LOCKED  <= 1'b0;
                            end
                            r_bad <= r_bad + BAD_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_SEARCH;
                        LOCKED  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gem_fiber_frame_rx.sv
// tb/tb_gem_fiber_frame_rx.sv - directed + randomized bench for gem_fiber_frame_rx against a frame-level model
module tb_gem_fiber_frame_rx;
    localparam int LOCK_FRAMES = 8;
    localparam int UNLOCK_ERRS = 4;
    localparam int CNT_W       = 16;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    localparam int K_GOOD    = 0;
    localparam int K_CORRUPT = 1;
    localparam int K_IDLE    = 2;

    localparam int M_SEARCH  = 0;
    localparam int M_CONFIRM = 1;
    localparam int M_LOCKED  = 2;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic [31:0]      RX_DATA = 32'h50BC50BC;
    logic [3:0]       RX_ISK = 4'b0101;
    logic [3:0]       RX_CODE_ERR = 4'b0000;
    logic             ERR_CNT_RST = 1'b0;
    logic [55:0]      GEM_DATA;
    logic             GEM_OVERFLOW;
    logic             FRAME_VALID;
    logic [7:0]       FRAME_SEP;
    logic             LOCKED;
    logic             LINK_IDLE;
    logic             FRAME_ERR;
    logic             SEQ_ERR;
    logic [CNT_W-1:0] FRAME_ERR_CNT;
    logic [CNT_W-1:0] SEQ_ERR_CNT;

    gem_fiber_frame_rx #(
        .LOCK_FRAMES(LOCK_FRAMES),
        .UNLOCK_ERRS(UNLOCK_ERRS),
        .CNT_W(CNT_W)
    ) dut (
        .TRG_CLK80(clk),
        .TRG_TXRESETDONE(resetn),
        .RX_DATA(RX_DATA),
        .RX_ISK(RX_ISK),
        .RX_CODE_ERR(RX_CODE_ERR),
        .ERR_CNT_RST(ERR_CNT_RST),
        .GEM_DATA(GEM_DATA),
        .GEM_OVERFLOW(GEM_OVERFLOW),
        .FRAME_VALID(FRAME_VALID),
        .FRAME_SEP(FRAME_SEP),
        .LOCKED(LOCKED),
        .LINK_IDLE(LINK_IDLE),
        .FRAME_ERR(FRAME_ERR),
        .SEQ_ERR(SEQ_ERR),
        .FRAME_ERR_CNT(FRAME_ERR_CNT),
        .SEQ_ERR_CNT(SEQ_ERR_CNT)
    );

    always #5 clk = ~clk;

    logic [7:0] rot [4] = '{8'hBC, 8'hF7, 8'hFB, 8'hFD};

    int n_checks = 0;
    int n_pass   = 0;
    int frame_no = 0;
    int fv_n, fe_n, se_n;

    int          m_st, m_good, m_bad, m_fe_cnt, m_se_cnt;
    logic [7:0]  m_exp, m_sep;
    logic [55:0] m_gem;
    logic        m_ovf, m_idle;
    int          e_fv, e_fe, e_se;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] rot_next(input logic [7:0] s);
        for (int i = 0; i < 4; i++)
            if (rot[i] == s) return rot[(i + 1) % 4];
        return 8'hBC;
    endfunction

    function automatic logic [7:0] exp_after(input logic [7:0] exp, input logic [7:0] sep);
        return (sep == 8'hFC) ? rot_next(exp) : rot_next(sep);
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic drive_word(input logic [31:0] d, input logic [3:0] k, input logic [3:0] ce, input logic rst);
        RX_DATA     = d;
        RX_ISK      = k;
        RX_CODE_ERR = ce;
        ERR_CNT_RST = rst;
        @(posedge clk);
        @(negedge clk);
        fv_n += int'(FRAME_VALID);
        fe_n += int'(FRAME_ERR);
        se_n += int'(SEQ_ERR);
    endtask

    task automatic do_reset();
        resetn      = 1'b0;
        RX_DATA     = 32'h50BC50BC;
        RX_ISK      = 4'b0101;
        RX_CODE_ERR = 4'b0000;
        ERR_CNT_RST = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_locked", {63'd0, LOCKED}, 64'd0);
        check("rst_link_idle", {63'd0, LINK_IDLE}, 64'd0);
        check("rst_fv", {63'd0, FRAME_VALID}, 64'd0);
        check("rst_gem", {8'd0, GEM_DATA}, 64'd0);
        check("rst_fe_cnt", {48'd0, FRAME_ERR_CNT}, 64'd0);
        check("rst_se_cnt", {48'd0, SEQ_ERR_CNT}, 64'd0);
        m_st = M_SEARCH; m_good = 0; m_bad = 0; m_fe_cnt = 0; m_se_cnt = 0;
        m_exp = 8'hBC; m_sep = 8'h00; m_gem = '0; m_ovf = 1'b0; m_idle = 1'b0;
        resetn = 1'b1;
    endtask

    // One frame = DATA+SEP pair (or two idle words); the model advances a whole frame at a time.
    task automatic send_frame(input int kind, input logic [55:0] d, input logic [7:0] sep, input logic rst);
        logic seq;
        fv_n = 0; fe_n = 0; se_n = 0;
        e_fv = 0; e_fe = 0; e_se = 0;
        frame_no++;
        if (kind == K_IDLE) begin
            drive_word(32'h50BC50BC, 4'b0101, 4'b0000, rst);
            drive_word(32'h50BC50BC, 4'b0101, 4'b0000, rst);
            m_st   = M_SEARCH;
            m_idle = 1'b1;
        end else begin
            drive_word(d[55:24], 4'b0000, (kind == K_CORRUPT) ? 4'b0010 : 4'b0000, rst);
            drive_word({d[23:0], sep}, 4'b0001, 4'b0000, rst);
            m_idle = 1'b0;
            if (kind == K_CORRUPT && m_st != M_SEARCH) begin
                e_fe = 1;
                m_fe_cnt = sat_inc(m_fe_cnt);
                if (m_st == M_CONFIRM) begin
                    m_st = M_SEARCH;
                end else begin
                    m_bad++;
                    if (m_bad == UNLOCK_ERRS) m_st = M_SEARCH;
                end
            end
            if (m_st == M_SEARCH) begin
                m_st   = M_CONFIRM;
                m_good = 0;
            end else begin
                seq = (sep != 8'hFC) && (sep != m_exp);
                if (seq) begin
                    e_se = 1;
                    m_se_cnt = sat_inc(m_se_cnt);
                end
                if (kind == K_GOOD) begin
                    if (m_st == M_CONFIRM) begin
                        if (seq) begin
                            m_st = M_SEARCH;
                        end else begin
                            m_good++;
                            if (m_good == LOCK_FRAMES) begin
                                m_st  = M_LOCKED;
                                m_bad = 0;
                            end
                        end
                    end else begin
                        e_fv  = 1;
                        m_gem = d;
                        m_sep = sep;
                        m_ovf = (sep == 8'hFC);
                        m_bad = 0;
                    end
                end
            end
            m_exp = exp_after(m_exp, sep);
        end
        if (rst) begin
            m_fe_cnt = 0;
            m_se_cnt = 0;
        end
        check($sformatf("f%0d_fv", frame_no), 64'(fv_n), 64'(e_fv));
        check($sformatf("f%0d_fe", frame_no), 64'(fe_n), 64'(e_fe));
        check($sformatf("f%0d_se", frame_no), 64'(se_n), 64'(e_se));
        check($sformatf("f%0d_locked", frame_no), {63'd0, LOCKED}, 64'(m_st == M_LOCKED));
        check($sformatf("f%0d_link_idle", frame_no), {63'd0, LINK_IDLE}, {63'd0, m_idle});
        check($sformatf("f%0d_fe_cnt", frame_no), {48'd0, FRAME_ERR_CNT}, 64'(m_fe_cnt));
        check($sformatf("f%0d_se_cnt", frame_no), {48'd0, SEQ_ERR_CNT}, 64'(m_se_cnt));
        check($sformatf("f%0d_gem", frame_no), {8'd0, GEM_DATA}, {8'd0, m_gem});
        check($sformatf("f%0d_sep", frame_no), {56'd0, FRAME_SEP}, {56'd0, m_sep});
        check($sformatf("f%0d_ovf", frame_no), {63'd0, GEM_OVERFLOW}, {63'd0, m_ovf});
    endtask

    task automatic send_good_expected(input int n);
        logic [63:0] r;
        for (int i = 0; i < n; i++) begin
            r = {$urandom(), $urandom()};
            send_frame(K_GOOD, r[55:0], m_exp, 1'b0);
        end
    endtask

    task automatic send_random(input int n);
        logic [63:0] r;
        logic [7:0]  s;
        int          p, kind;
        for (int i = 0; i < n; i++) begin
            r = {$urandom(), $urandom()};
            p = int'($urandom_range(0, 99));
            kind = (p < 86) ? K_GOOD : (p < 95) ? K_CORRUPT : K_IDLE;
            p = int'($urandom_range(0, 99));
            if (p < 80)      s = m_exp;
            else if (p < 88) s = 8'hFC;
            else             s = rot[$urandom_range(0, 3)];
            send_frame(kind, r[55:0], s, ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        do_reset();

        send_frame(K_IDLE, 56'd0, 8'd0, 1'b0);
        check("idle_link_idle", {63'd0, LINK_IDLE}, 64'd1);
        check("idle_locked", {63'd0, LOCKED}, 64'd0);

        for (int i = 0; i < 12; i++) begin
            send_frame(K_GOOD, 56'h123456789ABCDE, rot[i % 4], 1'b0);
            if (i == 7) check("lock_before_9th", {63'd0, LOCKED}, 64'd0);
            if (i == 8) begin
                check("lock_at_9th", {63'd0, LOCKED}, 64'd1);
                check("no_fv_at_9th", 64'(fv_n), 64'd0);
            end
            if (i == 9) begin
                check("fv_at_10th", 64'(fv_n), 64'd1);
                check("gem_at_10th", {8'd0, GEM_DATA}, 64'h00123456789ABCDE);
            end
        end

        send_frame(K_GOOD, 56'hA5A5A5A5A5A5A5, 8'hFC, 1'b0);
        check("fc_overflow", {63'd0, GEM_OVERFLOW}, 64'd1);
        check("fc_sep", {56'd0, FRAME_SEP}, 64'hFC);
        check("fc_no_seq", 64'(se_n), 64'd0);
        send_good_expected(1);
        check("after_fc_clean", 64'(se_n), 64'd0);

        while (m_exp != 8'hF7) send_good_expected(1);
        send_frame(K_GOOD, 56'h0F0F0F0F0F0F0F, 8'hFB, 1'b0);
        check("skip_seq_err", 64'(se_n), 64'd1);
        check("skip_seq_cnt", {48'd0, SEQ_ERR_CNT}, 64'd1);
        check("skip_delivered", 64'(fv_n), 64'd1);
        check("skip_locked", {63'd0, LOCKED}, 64'd1);

        for (int i = 0; i < 4; i++) begin
            send_frame(K_CORRUPT, 56'h11223344556677, m_exp, 1'b0);
            check("corrupt_fe", 64'(fe_n), 64'd1);
            check("corrupt_locked", {63'd0, LOCKED}, (i == 3) ? 64'd0 : 64'd1);
        end

        send_good_expected(9);
        check("relock", {63'd0, LOCKED}, 64'd1);
        send_frame(K_CORRUPT, 56'h0, m_exp, 1'b0);
        send_good_expected(2);
        check("single_corrupt_cnt", {48'd0, FRAME_ERR_CNT}, 64'd5);
        check("single_corrupt_locked", {63'd0, LOCKED}, 64'd1);

        for (int i = 0; i < 3; i++) send_frame(K_IDLE, 56'd0, 8'd0, 1'b0);
        check("burst_locked", {63'd0, LOCKED}, 64'd0);
        check("burst_link_idle", {63'd0, LINK_IDLE}, 64'd1);
        check("burst_fe_cnt", {48'd0, FRAME_ERR_CNT}, 64'd5);
        check("burst_se_cnt", {48'd0, SEQ_ERR_CNT}, 64'd1);

        send_good_expected(9);
        send_frame(K_CORRUPT, 56'h0, m_exp, 1'b1);
        check("cnt_rst_fe_strobe", 64'(fe_n), 64'd1);
        check("cnt_rst_fe_cnt", {48'd0, FRAME_ERR_CNT}, 64'd0);
        check("cnt_rst_se_cnt", {48'd0, SEQ_ERR_CNT}, 64'd0);

        send_random(300);

        @(negedge clk);
        do_reset();
        send_good_expected(1);
        check("post_reset_unlocked", {63'd0, LOCKED}, 64'd0);
        send_random(60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
